sync_capture_buffer: RTL and testbench
======================================

Name: sync_capture_buffer

Overview:
Downstream consumer of the synchronizer's clk-domain output. It takes the synchronized data word and its single-cycle valid pulse and captures a burst into a small FIFO when armed by an external trigger. The stored words are then read back in order for display and verification. It also keeps a sticky overflow flag and a saturating event counter, so CDC losses and duplications are observable after the fact.

Parameters:
WIDTH, 8, data word width
DEPTH, 8, FIFO depth in words; power of two, ≥2
TIMEOUT, 16, clk cycles without in_valid in CAPTURE before the capture closes
CNT_W, 8, event counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; low freezes all state
trg  in  1  arm request; asynchronous pin, synchronized internally
in_valid  in  1  single-cycle pulse from synchronizer: in_data is valid
in_data  in  WIDTH  synchronized data word
rd_en  in  1  read request
rd_data  out  WIDTH  read word, registered
rd_valid  out  1  rd_data valid this cycle
empty  out  1  FIFO holds 0 words
full  out  1  FIFO holds DEPTH words
count  out  clog2(DEPTH)+1  words stored
state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
overflow  out  1  sticky: a word was dropped since the last arm
evt_cnt  out  CNT_W  in_valid pulses seen since the last arm; saturating

Behaviour:
- Reset (async, rst_n=0) values: rd_data=0, rd_valid=0, empty=1, full=0, count=0, state=IDLE, overflow=0, evt_cnt=0. Internal pointers, the trg synchronizer and the timeout counter also clear. Reset applied mid-operation discards all stored data immediately.
- trg path: 2-FF synchronizer, third FF for rising-edge detect. arm = s2 & ~s3. state=ARMED is visible after the 3rd rising clk edge following trg going high. A level held high produces a single arm.
- arm in any state: flush FIFO (count=0), clear overflow, evt_cnt and timeout counter, go to ARMED. If in_valid coincides with arm, arm wins and the word is neither stored nor counted.
- IDLE: in_valid is ignored; nothing is stored or counted.
- ARMED: first in_valid writes the word, evt_cnt=1, go to CAPTURE.
- CAPTURE:
  - Each in_valid writes the word and increments evt_cnt.
  - A words_written counter (reset on arm) reaching DEPTH moves the block to DONE on that same edge.
  - The timeout counter increments on each cycle without in_valid and clears on in_valid. When it reaches TIMEOUT, go to DONE.
- DONE: no writes. Each in_valid increments evt_cnt and sets overflow. When empty=1 and no arm is pending, go to IDLE on the next edge.
- Reads, any state:
  - rd_en with empty=0 pops the oldest word. rd_data and rd_valid=1 appear on the following cycle (1-cycle latency).
  - rd_en with empty=1 is ignored and rd_valid=0; rd_data holds its last value.
  - rd_valid is a 1-cycle pulse per accepted read.
- Simultaneous write and read: both are performed and count is unchanged. Pointers wrap modulo DEPTH.
- Write when full (possible only via the read/write ordering edge case): the word is dropped and overflow=1.
- evt_cnt saturates at 2^CNT_W-1 and does not wrap.
- ena=0: state, FIFO, counters, outputs and trg synchronizer all hold; in_valid, rd_en and arm are ignored. rd_valid is forced to 0.

Test Plan:
1. Reset: rst_n=0 then 1, then 3 in_valid pulses in IDLE → all outputs at reset values, count=0, evt_cnt=0.
2. Full capture: trg pulse, then in_data=0x01..0x08 with in_valid every 3 cycles → state=ARMED 3 edges after trg; after the 8th write state=DONE, full=1, count=8. Eight rd_en pulses → rd_data 0x01..0x08 in order, each with rd_valid. Then empty=1 and state=IDLE.
3. Timeout: arm, then words 0xAB, 0xDA, 0xFF, then no in_valid → state=DONE exactly 16 cycles after the last write, count=3, overflow=0.
4. Overflow: after test 2's capture, with no reads, 2 extra in_valid → overflow=1, evt_cnt=10, count=8, FIFO contents unchanged.
5. Re-arm: 4 words captured, then trg coinciding with an in_valid → count=0, overflow=0, evt_cnt=0, state=ARMED; the coincident word is not stored.
6. Mid-op disruptions:
   - rst_n low mid-CAPTURE with 5 words stored → outputs take reset values asynchronously, before the next clk edge.
   - ena=0 for 10 cycles with in_valid and rd_en active → no change in count, state or evt_cnt.

Source files
------------

// File: rtl/sync_capture_buffer.sv
// sync_capture_buffer: arms on a synchronized trigger edge and captures a burst of valid words into a FIFO.
module sync_capture_buffer #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     trg,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [1:0]               state,
   output logic                     overflow,
   output logic [CNT_W-1:0]         evt_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
   state_t st, st_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt, ww;
   logic [TW-1:0] tmo;
   logic s1, s2, s3, rv;
   logic arm, vin, wr_req, wr, rd;
   assign arm      = ena & s2 & ~s3;
   assign vin      = ena & in_valid & ~arm;
   assign wr_req   = vin & (st == ARMED | st == CAPTURE);
   assign rd       = ena & rd_en & ~empty;
   assign wr       = wr_req & (~full | rd);
   assign empty    = cnt == '0;
   assign full     = cnt == (AW+1)'(DEPTH);
   assign count    = cnt;
   assign state    = st;
   assign rd_valid = rv & ena;
   always_comb begin
      st_nxt = arm ? ARMED :
               (st == ARMED   & vin) ? CAPTURE :
               (st == CAPTURE & vin & ww == (AW+1)'(DEPTH - 1)) ? DONE :
               (st == CAPTURE & ~vin & tmo == TW'(TIMEOUT - 1)) ? DONE :
               (st == DONE    & empty) ? IDLE : st;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else if (ena) st <= st_nxt;
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= in_data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {s1, s2, s3, rv, overflow} <= '0;
         rd_data <= '0;
         {wp, rp, cnt, ww, tmo}     <= '0;
         evt_cnt <= '0;
      end else if (ena) begin
         {s1, s2, s3} <= {trg, s1, s2};
         rv <= rd;
         if (rd) begin
            rd_data <= mem[rp];
            rp      <= rp + 1'b1;
         end
         if (arm) begin
            {wp, rp, cnt, ww, tmo} <= '0;
            overflow <= 1'b0;
            evt_cnt  <= '0;
         end else begin
            if (wr) wp <= wp + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
            if (wr_req) ww <= ww + 1'b1;
            tmo <= (st == CAPTURE & ~vin) ? tmo + 1'b1 : '0;
            if (vin & st != IDLE & ~&evt_cnt) evt_cnt <= evt_cnt + 1'b1;
            // late words after a closed capture, or a full FIFO with no pop, are lost
            if (vin & st == DONE | wr_req & ~wr) overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sync_capture_buffer.sv
// tb_sync_capture_buffer: directed vector and sequence checks for sync_capture_buffer.
module tb_sync_capture_buffer;
   logic clk = 0, rst_n = 0, ena = 1, trg = 0, in_valid = 0, rd_en = 0;
   logic [7:0] in_data = 0, rd_data, evt_cnt;
   logic rd_valid, empty, full, overflow;
   logic [3:0] count;
   logic [1:0] state;
   int tests = 0, fails = 0;

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       re;
      logic       e_rv;
      logic [7:0] e_rd;
      logic [3:0] e_cnt;
      logic [1:0] e_st;
   } vec_t;
   vec_t tbl [18];

   sync_capture_buffer dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .trg(trg), .in_valid(in_valid), .in_data(in_data),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
      .count(count), .state(state), .overflow(overflow), .evt_cnt(evt_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_arm();
      trg = 1;
      repeat (3) tick();
      chk("arm_state", state, 1);
      trg = 0;
      repeat (3) tick();
   endtask

   task automatic wr_word(input logic [7:0] d);
      in_valid = 1;
      in_data  = d;
      tick();
      in_valid = 0;
   endtask

   initial begin
      tbl[0] = '{1, 8'hEE, 0, 0, 8'h00, 8, 3};
      tbl[1] = '{1, 8'hEE, 0, 0, 8'h00, 8, 3};
      for (int k = 1; k <= 8; k++) begin
         tbl[2*k]   = '{0, 8'h00, 1, 1, 8'(k), 4'(8 - k), 3};
         tbl[2*k+1] = '{0, 8'h00, 0, 0, 8'(k), 4'(8 - k), (k == 8) ? 2'd0 : 2'd3};
      end
      // The loop above fills 2..17; entries 0..1 are the post-capture overflow words.
      @(negedge clk);
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_state", state, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_evt", evt_cnt, 0);
      rst_n = 1;
      tick();
      repeat (3) begin
         wr_word(8'h55);
         tick();
      end
      chk("idle_count", count, 0);
      chk("idle_evt", evt_cnt, 0);
      chk("idle_state", state, 0);

      // full capture with trigger latency
      trg = 1;
      tick();
      chk("trg_edge1", state, 0);
      tick();
      chk("trg_edge2", state, 0);
      tick();
      chk("trg_edge3", state, 1);
      for (int i = 1; i <= 8; i++) begin
         wr_word(8'(i));
         if (i == 1) begin
            chk("first_state", state, 2);
            chk("first_evt", evt_cnt, 1);
         end
         if (i < 8) repeat (2) tick();
      end
      chk("cap_state", state, 3);
      chk("cap_full", full, 1);
      chk("cap_count", count, 8);
      chk("cap_evt", evt_cnt, 8);
      chk("cap_overflow", overflow, 0);

      for (int i = 0; i < 18; i++) begin
         in_valid = tbl[i].iv;
         in_data  = tbl[i].d;
         rd_en    = tbl[i].re;
         tick();
         chk($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].e_rv);
         chk($sformatf("v%0d_rd_data", i), rd_data, tbl[i].e_rd);
         chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
         chk($sformatf("v%0d_state", i), state, tbl[i].e_st);
         if (i == 1) begin
            chk("ovf_flag", overflow, 1);
            chk("ovf_evt", evt_cnt, 10);
         end
      end
      in_valid = 0;
      rd_en    = 0;
      chk("drain_evt", evt_cnt, 10);
      chk("drain_empty", empty, 1);
      trg = 0;
      repeat (3) tick();

      // timeout closes capture 16 cycles after the last word
      do_arm();
      chk("rearm_ovf_clr", overflow, 0);
      in_valid = 1;
      in_data = 8'hAB; tick();
      in_data = 8'hDA; tick();
      in_data = 8'hFF; tick();
      in_valid = 0;
      repeat (15) tick();
      chk("tmo_15", state, 2);
      tick();
      chk("tmo_16", state, 3);
      chk("tmo_count", count, 3);
      chk("tmo_overflow", overflow, 0);
      rd_en = 1;
      tick(); chk("tmo_rd0", rd_data, 8'hAB);
      tick(); chk("tmo_rd1", rd_data, 8'hDA);
      tick(); chk("tmo_rd2", rd_data, 8'hFF);
      chk("tmo_rv", rd_valid, 1);
      rd_en = 0;
      tick();
      chk("tmo_idle", state, 0);

      // re-arm coinciding with a valid word
      do_arm();
      for (int i = 0; i < 4; i++) wr_word(8'h11 + 8'(i));
      chk("pre_rearm_count", count, 4);
      chk("pre_rearm_evt", evt_cnt, 4);
      trg = 1;
      tick();
      tick();
      in_valid = 1;
      in_data  = 8'h99;
      tick();
      in_valid = 0;
      trg = 0;
      chk("rearm_count", count, 0);
      chk("rearm_evt", evt_cnt, 0);
      chk("rearm_ovf", overflow, 0);
      chk("rearm_state", state, 1);
      repeat (3) tick();
      wr_word(8'h77);
      chk("post_rearm_count", count, 1);
      chk("post_rearm_evt", evt_cnt, 1);
      rd_en = 1;
      tick();
      rd_en = 0;
      chk("post_rearm_rd", rd_data, 8'h77);

      // asynchronous reset mid-capture
      for (int i = 0; i < 5; i++) wr_word(8'hA0 + 8'(i));
      chk("mid_count", count, 5);
      #2 rst_n = 0;
      #1;
      chk("async_count", count, 0);
      chk("async_state", state, 0);
      chk("async_empty", empty, 1);
      chk("async_evt", evt_cnt, 0);
      chk("async_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1;
      tick();

      // enable freeze
      do_arm();
      wr_word(8'hC1);
      wr_word(8'hC2);
      rd_en = 1;
      tick();
      chk("pre_frz_rv", rd_valid, 1);
      chk("pre_frz_rd", rd_data, 8'hC1);
      ena = 0;
      in_valid = 1;
      in_data = 8'h5A;
      trg = 1;
      #1;
      chk("frz_rv_forced", rd_valid, 0);
      repeat (10) tick();
      chk("frz_count", count, 1);
      chk("frz_state", state, 2);
      chk("frz_evt", evt_cnt, 2);
      chk("frz_rd_data", rd_data, 8'hC1);
      trg = 0;
      in_valid = 0;
      ena = 1;
      tick();
      rd_en = 0;
      chk("thaw_rv", rd_valid, 1);
      chk("thaw_rd", rd_data, 8'hC2);
      chk("thaw_count", count, 0);
      chk("thaw_state", state, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
